// File: rtl/game_ctl.sv
// Bug-hunt game sequencer: start/play/over FSM, bug placement from a free-running LFSR,
// click hit scoring and frame countdown. Runs on pclk with vsync as the frame tick.
module game_ctl #(
  parameter int unsigned SCREEN_W    = 800,
  parameter int unsigned SCREEN_H    = 600,
  parameter int unsigned BUG_W       = 64,
  parameter int unsigned BUG_H       = 64,
  parameter int unsigned BUG_PERIOD  = 60,
  parameter int unsigned GAME_FRAMES = 1800,
  parameter int unsigned BTN_X0      = 300,
  parameter int unsigned BTN_Y0      = 250,
  parameter int unsigned BTN_X1      = 499,
  parameter int unsigned BTN_Y1      = 349
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        vsync_in,
  input  logic        mouse_left,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  output logic        screen_sel,
  output logic [11:0] x_bugpos,
  output logic [11:0] y_bugpos,
  output logic [7:0]  score,
  output logic [10:0] frames_left,
  output logic        game_over
);

  localparam int unsigned TW = (BUG_PERIOD > 1) ? $clog2(BUG_PERIOD) : 1;
  localparam logic [9:0]  XLim = 10'(SCREEN_W - BUG_W);
  localparam logic [9:0]  YLim = 10'(SCREEN_H - BUG_H);

  typedef enum logic [1:0] {StIdle, StPlay, StOver} state_e;

  state_e          state_q, state_d;
  logic            ml_s1_q, ml_s2_q, ml_prev_q, click_q;
  logic            vs_prev_q, tick;
  logic [15:0]     lfsr_q;
  logic [9:0]      cx, cy;
  logic [11:0]     x_new, y_new;
  logic [11:0]     x_bug_q, x_bug_d, y_bug_q, y_bug_d;
  logic [7:0]      score_q, score_d;
  logic [10:0]     frames_q, frames_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            sel_q, over_q;
  logic            in_btn, hit;
  logic [12:0]     x_end, y_end;

  assign tick = vsync_in & ~vs_prev_q;

  // Fold the 10-bit LFSR slices into the legal top-left range.
  assign cx    = lfsr_q[9:0];
  assign cy    = lfsr_q[15:6];
  assign x_new = {2'b00, (cx > XLim) ? (cx - XLim) : cx};
  assign y_new = {2'b00, (cy > YLim) ? (cy - YLim) : cy};

  assign in_btn = (xpos >= 12'(BTN_X0)) && (xpos <= 12'(BTN_X1)) &&
                  (ypos >= 12'(BTN_Y0)) && (ypos <= 12'(BTN_Y1));

  assign x_end = {1'b0, x_bug_q} + 13'(BUG_W);
  assign y_end = {1'b0, y_bug_q} + 13'(BUG_H);
  assign hit   = (xpos >= x_bug_q) && ({1'b0, xpos} < x_end) &&
                 (ypos >= y_bug_q) && ({1'b0, ypos} < y_end);

  always_comb begin
    state_d  = state_q;
    score_d  = score_q;
    frames_d = frames_q;
    timer_d  = timer_q;
    x_bug_d  = x_bug_q;
    y_bug_d  = y_bug_q;
    unique case (state_q)
      StIdle: begin
        if (click_q && in_btn) begin
          state_d  = StPlay;
          score_d  = 8'd0;
          frames_d = 11'(GAME_FRAMES);
          timer_d  = '0;
          x_bug_d  = x_new;
          y_bug_d  = y_new;
        end
      end
      StPlay: begin
        if (tick) begin
          frames_d = frames_q - 11'd1;
          if (timer_q == TW'(BUG_PERIOD - 1)) begin
            timer_d = '0;
            x_bug_d = x_new;
            y_bug_d = y_new;
          end else begin
            timer_d = timer_q + TW'(1);
          end
          if (frames_q == 11'd1) state_d = StOver;
        end
        // A hit overrides the timer outcome; both relocate to the same LFSR sample.
        if (click_q && hit) begin
          if (score_q != 8'hFF) score_d = score_q + 8'd1;
          timer_d = '0;
          x_bug_d = x_new;
          y_bug_d = y_new;
        end
      end
      StOver: begin
        if (click_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      ml_s1_q   <= 1'b0;
      ml_s2_q   <= 1'b0;
      ml_prev_q <= 1'b0;
      click_q   <= 1'b0;
      vs_prev_q <= 1'b0;
      lfsr_q    <= 16'hACE1;
      state_q   <= StIdle;
      score_q   <= 8'd0;
      frames_q  <= 11'(GAME_FRAMES);
      timer_q   <= '0;
      x_bug_q   <= 12'((SCREEN_W - BUG_W) / 2);
      y_bug_q   <= 12'((SCREEN_H - BUG_H) / 2);
      sel_q     <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      ml_s1_q   <= mouse_left;
      ml_s2_q   <= ml_s1_q;
      ml_prev_q <= ml_s2_q;
      click_q   <= ml_s2_q & ~ml_prev_q;
      vs_prev_q <= vsync_in;
      lfsr_q    <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
      state_q   <= state_d;
      score_q   <= score_d;
      frames_q  <= frames_d;
      timer_q   <= timer_d;
      x_bug_q   <= x_bug_d;
      y_bug_q   <= y_bug_d;
      sel_q     <= (state_d == StPlay);
      over_q    <= (state_d == StOver);
    end
  end

  assign screen_sel  = sel_q;
  assign game_over   = over_q;
  assign score       = score_q;
  assign frames_left = frames_q;
  assign x_bugpos    = x_bug_q;
  assign y_bugpos    = y_bug_q;

endmodule
